// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-drive signals of alu_cmd_sequencer.
// The sequencer takes the slave view; decode logic and the ALU take the master view.
interface alu_cmd_sequencer_if #(
    parameter int DW   = 16,
    parameter int NREG = 4
);
    localparam int RW = $clog2(NREG);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [RW-1:0] cmd_rd;
    logic [RW-1:0] cmd_rs1;
    logic [RW-1:0] cmd_rs2;
    logic          cmd_imm_sel;
    logic [DW-1:0] cmd_imm;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_data, rsp_zero, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_sel, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_data, rsp_zero, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences commands through a combinational ALU with a small register file.
// Optional: define ALU_CMD_SEQ_R0_ZERO_EN to hard-wire register 0 to zero.
module alu_cmd_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOT  = 3'b100,
        OP_LOAD = 3'b111
    } op_t;

    state_t        state, state_nxt;
    logic          started;
    logic [DW-1:0] regs [NREG];
    logic [RW-1:0] rd_q;
    logic [DW-1:0] alu_a_q, alu_b_q, rsp_data_q;
    logic [2:0]    alu_op_q;
    logic          rsp_zero_q, rsp_err_q;

    logic          accept;
    logic          is_alu_op, is_load;
    logic [DW-1:0] rs1_val, rs2_val;
    logic          wr_en;
    logic [RW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    // started keeps cmd_ready low until the first edge after reset release
    assign bus.cmd_ready = started & (state == IDLE);
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign is_alu_op     = (bus.cmd_op <= OP_NOT);
    assign is_load       = (bus.cmd_op == OP_LOAD);

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = (state == RESPOND);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        rs1_val = regs[bus.cmd_rs1];
        rs2_val = regs[bus.cmd_rs2];
`ifdef ALU_CMD_SEQ_R0_ZERO_EN
        if (bus.cmd_rs1 == '0) rs1_val = '0;
        if (bus.cmd_rs2 == '0) rs2_val = '0;
`endif
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.cmd_rd;
        wr_data = bus.cmd_imm;
        if (state == IDLE && accept && is_load) begin
            wr_en = 1'b1;
        end else if (state == CAPTURE) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = bus.alu_result;
        end
`ifdef ALU_CMD_SEQ_R0_ZERO_EN
        if (wr_addr == '0) wr_en = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_alu_op ? ISSUE : RESPOND;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESPOND;
            RESPOND: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_alu_op) begin
                            alu_a_q  <= rs1_val;
                            alu_b_q  <= bus.cmd_imm_sel ? bus.cmd_imm : rs2_val;
                            alu_op_q <= bus.cmd_op;
                            rd_q     <= bus.cmd_rd;
                        end else if (is_load) begin
                            rsp_data_q <= bus.cmd_imm;
                            rsp_zero_q <= (bus.cmd_imm == '0);
                            rsp_err_q  <= 1'b0;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_zero_q <= 1'b0;
                            rsp_err_q  <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    rsp_data_q <= bus.alu_result;
                    rsp_zero_q <= bus.alu_zero;
                    rsp_err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 16-bit ALU interface (A, B, ALUOp in; Result, Zero out).
- Accepts operation commands on a valid/ready channel and reads operands from a 4x16 register file.
- Drives the ALU with registered operands, captures Result/Zero, writes back the destination register and returns a response on a second valid/ready channel.
- Sits between the instruction decode logic and the combinational ALU.

Parameters:
- DW, 16, datapath width; must match the ALU width.
- NREG, 4, number of register-file entries; register index width is log2(NREG) = 2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, 111 LOAD, 101/110 illegal.
- cmd_rd  in  2  destination register.
- cmd_rs1  in  2  source register for A.
- cmd_rs2  in  2  source register for B (used when cmd_imm_sel=0).
- cmd_imm_sel  in  1  1: B operand = cmd_imm.
- cmd_imm  in  DW  immediate value, or the LOAD value.
- alu_a  out  DW  drives ALU A.
- alu_b  out  DW  drives ALU B.
- alu_op  out  3  drives ALU ALUOp.
- alu_result  in  DW  ALU Result.
- alu_zero  in  1  ALU Zero.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DW  result written to rd (0 on error).
- rsp_zero  out  1  rsp_data == 0 (ALU Zero for ALU ops).
- rsp_err  out  1  illegal opcode.

Behaviour:
- Reset (async, while rst_n=0):
  - state = IDLE; all register-file entries = 0.
  - alu_a, alu_b, alu_op, rsp_data = 0; rsp_valid, rsp_zero, rsp_err = 0.
  - cmd_ready = 0 while in reset; cmd_ready = 1 from the first edge after release.
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- cmd_ready = 1 only in IDLE. A command is accepted on a rising edge where cmd_valid & cmd_ready.
- IDLE, on accept, by opcode:
  - ALU op (000-100): latch alu_a = reg[rs1], alu_b = (imm_sel ? imm : reg[rs2]), alu_op = cmd_op, rd latched; go to ISSUE.
  - LOAD (111): reg[rd] = cmd_imm; rsp_data = cmd_imm; rsp_zero = (cmd_imm == 0); rsp_err = 0; go to RESPOND.
  - Illegal (101, 110): rsp_data = 0, rsp_zero = 0, rsp_err = 1, no writeback; go to RESPOND.
- ISSUE: ALU inputs are stable for one full cycle. No other action; go to CAPTURE.
- CAPTURE: sample alu_result/alu_zero into rsp_data/rsp_zero; write reg[rd] = alu_result; rsp_err = 0; go to RESPOND.
- RESPOND: rsp_valid = 1. Hold rsp_data, rsp_zero, rsp_err stable until rsp_valid & rsp_ready at an edge, then go to IDLE with rsp_valid = 0.
- Latency (accept edge = N, rsp_ready held high):
  - ALU op: rsp_valid rises after edge N+2; response completes at edge N+3; next accept possible at N+4.
  - LOAD / illegal: rsp_valid rises after edge N; response completes at N+1.
- Operand read is from register state before the accept edge.
  - rs == rd of the previous command sees the written-back value, because writeback precedes RESPOND.
- alu_a, alu_b, alu_op hold their last values outside ISSUE/CAPTURE; they are never X.
- Arithmetic: wrap-around modulo 2^DW is performed by the ALU; the sequencer does no width extension. NOT ignores alu_b, but alu_b is still driven.
- Back-pressure: rsp_ready low holds RESPOND indefinitely and cmd_ready stays 0. No command is lost or reordered (single outstanding command).
- Reset asserted mid-operation aborts the operation: no writeback and no response. The register file clears.

Optional Feature:
- Macro: ALU_CMD_SEQ_R0_ZERO_EN.
- Defined: register 0 always reads as 0 and writes to rd=0 are discarded. The response still reports the computed value.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- LOAD r1=0x000A, LOAD r2=0x0005, ADD rd=3 rs1=1 rs2=2 -> rsp_data=0x000F, rsp_zero=0, rsp_err=0; rsp_valid rises 2 edges after the ADD accept; r3=0x000F.
- SUB r1-r2 -> 0x0005; SUB r2-r2 -> rsp_data=0x0000, rsp_zero=1; SUB r2-r1 -> 0xFFFB (wrap).
- LOAD r1=0x00FF, AND with imm 0x0F0F -> 0x000F; OR with imm 0x0F0F -> 0x0FFF; NOT r1 -> 0xFF00.
- cmd_op=101 -> rsp_err=1, rsp_data=0, no register changes; next ADD completes normally.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, new cmd_valid ignored; release -> single handshake, then IDLE.
- Assert rst_n=0 during ISSUE of ADD rd=1 -> outputs 0 immediately, r1 reads 0 afterwards, no response. With ALU_CMD_SEQ_R0_ZERO_EN: LOAD r0=0x1234 then ADD r0+r0 -> rsp_data=0x0000, rsp_zero=1.
